// File: rtl/flit_sender.sv
// Link transmitter: drains a source FIFO packet by packet (header, size, payload)
// under credit flow control. Optional stall counter: define FLIT_SENDER_STALL_CNT_EN.
`ifndef TAM_FLIT
`define TAM_FLIT 16
`endif
`ifndef TAM_BUFFER
`define TAM_BUFFER 8
`endif

module flit_sender #(
  parameter int WIDTH = `TAM_FLIT,
  parameter int DEPTH = `TAM_BUFFER
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [WIDTH-1:0]       i_head,
  input  logic [$clog2(DEPTH):0] i_counter,
  output logic                   o_pull,
  output logic                   o_tx,
  output logic [WIDTH-1:0]       o_data,
  input  logic                   i_credit,
  output logic                   o_busy,
  output logic                   o_packet_done
`ifdef FLIT_SENDER_STALL_CNT_EN
  ,
  output logic [15:0]            o_stall_cnt
`endif
);

  typedef enum logic [1:0] {S_HEADER, S_SIZE, S_PAYLOAD} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] remaining, remaining_next;
  logic             last, last_next;
  logic             xfer;

  assign xfer = o_tx && i_credit;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state     <= S_HEADER;
      remaining <= '0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
    end
  end

  // The FSM names the flit about to be loaded, so it only moves on a pull.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    last_next      = 1'b0;
    if (o_pull) begin
      case (state)
        S_HEADER: state_next = S_SIZE;
        S_SIZE: begin
          remaining_next = i_head;
          if (i_head == '0) begin
            last_next  = 1'b1;
            state_next = S_HEADER;
          end else begin
            state_next = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          remaining_next = remaining - WIDTH'(1);
          if (remaining == WIDTH'(1)) begin
            last_next  = 1'b1;
            state_next = S_HEADER;
          end
        end
        default: state_next = S_HEADER;
      endcase
    end
  end

  always_comb begin
    o_pull = i_rst && (i_counter != '0) && (!o_tx || i_credit);
    o_busy = (state != S_HEADER) || o_tx;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_tx          <= 1'b0;
      o_data        <= '0;
      last          <= 1'b0;
      o_packet_done <= 1'b0;
    end else begin
      if (o_pull) begin
        o_tx   <= 1'b1;
        o_data <= i_head;
        last   <= last_next;
      end else if (xfer) begin
        o_tx <= 1'b0;
      end
      o_packet_done <= xfer && last;
    end
  end

`ifdef FLIT_SENDER_STALL_CNT_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst)
      o_stall_cnt <= '0;
    else if (o_tx && !i_credit && (o_stall_cnt != '1))
      o_stall_cnt <= o_stall_cnt + 16'd1;
  end
`endif

endmodule
